ram_access_ctrl: RTL

//  CPU-side initiator for the cpu_ram_if RAM port: turns byte-addressed load/store requests from the

---
 rtl/ram_access_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// Byte-addressed load/store front end for a word-wide RAM port: aligns and extends loads,
// performs sub-word stores as read-modify-write, and rejects misaligned accesses.
module ram_access_ctrl #(
   parameter int ADDR_W = 14,
   parameter int RD_LAT = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              mem_req,
   input  logic              mem_wen,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_wdata,
   output logic              mem_busy,
   output logic              mem_done,
   output logic              mem_err,
   output logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_store,
   output logic              ram_wen,
   output logic [1:0]        ram_width,
   input  logic [31:0]       ram_load
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   state_t            state_q, state_d;
   logic              wen_q, wen_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        lane_q, lane_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              mem_busy_q, mem_busy_d;
   logic              mem_done_q, mem_done_d;
   logic              mem_err_q, mem_err_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_store_q, ram_store_d;
   logic              ram_wen_q, ram_wen_d;

   logic unused_addr_s;
   assign unused_addr_s = ^mem_addr[31:ADDR_W+2];

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = lane[0];
         default: bad = (lane != 2'b00);
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {lane, 3'b000};
      case (size)
         2'b00:   res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: res = word;
      endcase
      return res;
   endfunction

   // Only the addressed lanes take new data; the rest come from the word just read.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wdata,
                                               input logic [1:0] lane, input logic [1:0] size);
      logic [31:0] mask;
      logic [31:0] data;
      case (size)
         2'b00: begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            data = {24'd0, wdata[7:0]} << {lane, 3'b000};
         end
         2'b01: begin
            mask = 32'h0000_FFFF << {lane, 3'b000};
            data = {16'd0, wdata} << {lane, 3'b000};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = {16'd0, wdata};
         end
      endcase
      return (word & ~mask) | (data & mask);
   endfunction

   always_comb begin
      state_d     = state_q;
      wen_d       = wen_q;
      size_d      = size_q;
      uns_d       = uns_q;
      lane_d      = lane_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      mem_err_d   = 1'b0;
      mem_rdata_d = mem_rdata_q;
      ram_addr_d  = ram_addr_q;
      ram_store_d = ram_store_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_req) begin
               wen_d   = mem_wen;
               size_d  = mem_size;
               uns_d   = mem_unsigned;
               lane_d  = mem_addr[1:0];
               wdata_d = mem_wdata[15:0];
               if (is_misaligned(mem_size, mem_addr[1:0])) begin
                  mem_err_d = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  ram_addr_d = mem_addr[ADDR_W+1:2];
                  if (mem_wen && mem_size[1]) begin
                     ram_store_d = mem_wdata;
                     state_d     = ST_WRITE;
                  end else begin
                     cnt_d   = CNT_INIT;
                     state_d = ST_RD_WAIT;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (cnt_q == 3'd0) begin
               if (wen_q) begin
                  ram_store_d = store_merge(ram_load, wdata_q, lane_q, size_q);
                  state_d     = ST_WRITE;
               end else begin
                  mem_rdata_d = load_align(ram_load, lane_q, size_q, uns_q);
                  state_d     = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      mem_busy_d = (state_d != ST_IDLE);
      mem_done_d = (state_d == ST_DONE);
      ram_wen_d  = (state_d == ST_WRITE);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         wen_q       <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= 16'd0;
         cnt_q       <= 3'd0;
         mem_busy_q  <= 1'b0;
         mem_done_q  <= 1'b0;
         mem_err_q   <= 1'b0;
         mem_rdata_q <= 32'd0;
         ram_addr_q  <= '0;
         ram_store_q <= 32'd0;
         ram_wen_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         lane_q      <= lane_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         mem_busy_q  <= mem_busy_d;
         mem_done_q  <= mem_done_d;
         mem_err_q   <= mem_err_d;
         mem_rdata_q <= mem_rdata_d;
         ram_addr_q  <= ram_addr_d;
         ram_store_q <= ram_store_d;
         ram_wen_q   <= ram_wen_d;
      end
   end

   assign mem_busy  = mem_busy_q;
   assign mem_done  = mem_done_q;
   assign mem_err   = mem_err_q;
   assign mem_rdata = mem_rdata_q;
   assign ram_addr  = ram_addr_q;
   assign ram_store = ram_store_q;
   assign ram_wen   = ram_wen_q;
   assign ram_width = 2'b10;

endmodule
